// File: rtl/y86_seq_ctrl.sv
// y86_seq_ctrl: multi-cycle stage sequencer for the Y86-64 SEQ datapath, owning PC, status and counters.
module y86_seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      start_pc,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic [63:0]      next_pc,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic [63:0]      pc,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED} state_t;
  state_t state;
  logic is_mem;
  always_comb begin
    is_mem = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    busy = state != IDLE && state != HALTED;
    imem_req = state == FETCH;
    dmem_req = state == MEMORY;
    fetch_en = imem_req && imem_ack;
    decode_en = state == DECODE;
    exec_en = state == EXECUTE;
    mem_en = dmem_req && dmem_ack && !dmem_error;
    wb_en = state == WRITEBACK;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      stat <= 3'd1;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (busy && ~&cycle_count) cycle_count <= cycle_count + 1'b1;
      case (state)
        IDLE, HALTED: if (start) begin
          pc <= start_pc;
          stat <= 3'd1;
          cycle_count <= '0;
          instr_count <= '0;
          state <= FETCH;
        end
        FETCH: if (imem_ack) begin
          stat <= imem_error ? 3'd3 : !instr_valid ? 3'd4 : stat;
          state <= (imem_error || !instr_valid) ? HALTED : DECODE;
        end
        DECODE: state <= EXECUTE;
        EXECUTE: state <= is_mem ? MEMORY : WRITEBACK;
        MEMORY: if (dmem_ack) begin
          stat <= dmem_error ? 3'd3 : stat;
          state <= dmem_error ? HALTED : WRITEBACK;
        end
        WRITEBACK: state <= PCUPD;
        PCUPD: begin
          pc <= next_pc;
          if (~&instr_count) instr_count <= instr_count + 1'b1;
          stat <= icode == 4'h0 ? 3'd2 : stat;
          state <= icode == 4'h0 ? HALTED : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_y86_seq_ctrl.sv
// tb_y86_seq_ctrl: scoreboard bench; each instruction pushes its predicted outcome, popped when it completes.
module tb_y86_seq_ctrl;
  localparam logic [63:0] RPC = 64'h100;
  logic clk = 0, rst = 1, start = 0, instr_valid = 1, imem_error = 0, imem_ack = 0, dmem_ack = 0, dmem_error = 0;
  logic [63:0] start_pc = 0, next_pc = 0, pc;
  logic [3:0] icode = 0;
  logic imem_req, dmem_req, fetch_en, decode_en, exec_en, mem_en, wb_en, busy;
  logic [2:0] stat;
  logic [31:0] cycle_count, instr_count;
  typedef struct {logic [63:0] pc; logic [2:0] stat; logic busy; int icnt, ccnt, cycles, nf, nd, ne, nm, nw, ni, ndm;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, m_icnt = 0, m_cyc = 0;
  logic [63:0] m_pc;

  y86_seq_ctrl #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .next_pc(next_pc), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .pc(pc), .imem_req(imem_req), .dmem_req(dmem_req), .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en), .stat(stat), .busy(busy),
    .cycle_count(cycle_count), .instr_count(instr_count));

  always #5 clk = ~clk;

  task automatic do_start(input logic [63:0] p);
    imem_ack = 0; dmem_ack = 0;
    start = 1; start_pc = p;
    @(negedge clk);
    start = 0;
    m_pc = p; m_icnt = 0; m_cyc = 0;
  endtask

  // Runs one instruction from its first FETCH cycle until the next fetch starts or the core stops.
  task automatic exec_instr(input logic [3:0] ic, input logic v, input logic ie, input logic de,
                            input logic [63:0] np, input int iw, input int dw, input logic poke, input string name);
    exp_t e, a;
    int icw = 0, dcw = 0;
    bit mem, done = 0;
    mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    e = '{default: 0};
    e.ni = iw + 1; e.nf = 1; e.pc = m_pc; e.icnt = m_icnt; e.busy = 0;
    if (ie || !v) begin
      e.stat = ie ? 3'd3 : 3'd4; e.cycles = iw + 1;
    end else if (mem && de) begin
      e.stat = 3'd3; e.cycles = iw + 4 + dw; e.nd = 1; e.ne = 1; e.ndm = dw + 1;
    end else begin
      e.cycles = iw + 5 + (mem ? dw + 1 : 0); e.nd = 1; e.ne = 1; e.nw = 1; e.nm = mem ? 1 : 0;
      e.ndm = mem ? dw + 1 : 0; e.pc = np; e.icnt = m_icnt + 1;
      e.stat = ic == 4'h0 ? 3'd2 : 3'd1; e.busy = ic != 4'h0;
    end
    m_pc = e.pc; m_icnt = e.icnt; m_cyc += e.cycles; e.ccnt = m_cyc;
    q.push_back(e);
    icode = ic; instr_valid = v; imem_error = ie; dmem_error = de; next_pc = np;
    a = '{default: 0};
    for (int k = 0; k < 100 && !done; k++) begin
      if ((a.nf > 0 && imem_req) || !busy) done = 1;
      else begin
        imem_ack = imem_req && icw == iw;
        dmem_ack = dmem_req && dcw == dw;
        if (imem_req) icw++;
        if (dmem_req) dcw++;
        if (poke) begin start = k == 1; start_pc = 64'hdead; end
        #1;
        a.cycles++; a.nf += int'(fetch_en); a.nd += int'(decode_en); a.ne += int'(exec_en);
        a.nm += int'(mem_en); a.nw += int'(wb_en); a.ni += int'(imem_req); a.ndm += int'(dmem_req);
        @(negedge clk);
      end
    end
    start = 0;
    checks++; if (!done) begin fails++; $display("FAIL %s timeout: instruction never completed", name); end
    a.pc = pc; a.stat = stat; a.busy = busy; a.icnt = int'(instr_count); a.ccnt = int'(cycle_count);
    e = q.pop_front();
    checks++; if (a.pc !== e.pc) begin fails++; $display("FAIL %s pc got %h exp %h", name, a.pc, e.pc); end
    checks++; if (a.stat !== e.stat) begin fails++; $display("FAIL %s stat got %0d exp %0d", name, a.stat, e.stat); end
    checks++; if (a.busy !== e.busy) begin fails++; $display("FAIL %s busy got %b exp %b", name, a.busy, e.busy); end
    checks++; if (a.icnt != e.icnt) begin fails++; $display("FAIL %s instr_count got %0d exp %0d", name, a.icnt, e.icnt); end
    checks++; if (a.ccnt != e.ccnt) begin fails++; $display("FAIL %s cycle_count got %0d exp %0d", name, a.ccnt, e.ccnt); end
    checks++; if (a.cycles != e.cycles) begin fails++; $display("FAIL %s latency got %0d exp %0d", name, a.cycles, e.cycles); end
    checks++; if (a.nf != e.nf) begin fails++; $display("FAIL %s fetch_en pulses got %0d exp %0d", name, a.nf, e.nf); end
    checks++; if (a.nd != e.nd) begin fails++; $display("FAIL %s decode_en pulses got %0d exp %0d", name, a.nd, e.nd); end
    checks++; if (a.ne != e.ne) begin fails++; $display("FAIL %s exec_en pulses got %0d exp %0d", name, a.ne, e.ne); end
    checks++; if (a.nm != e.nm) begin fails++; $display("FAIL %s mem_en pulses got %0d exp %0d", name, a.nm, e.nm); end
    checks++; if (a.nw != e.nw) begin fails++; $display("FAIL %s wb_en pulses got %0d exp %0d", name, a.nw, e.nw); end
    checks++; if (a.ni != e.ni) begin fails++; $display("FAIL %s imem_req cycles got %0d exp %0d", name, a.ni, e.ni); end
    checks++; if (a.ndm != e.ndm) begin fails++; $display("FAIL %s dmem_req cycles got %0d exp %0d", name, a.ndm, e.ndm); end
  endtask

  task automatic test_reset;
    imem_ack = 1; dmem_ack = 1;
    @(negedge clk);
    checks++; if (pc !== RPC) begin fails++; $display("FAIL reset pc got %h exp %h", pc, RPC); end
    checks++; if (stat !== 3'd1 || busy !== 1'b0) begin fails++; $display("FAIL reset stat/busy got %0d/%b exp 1/0", stat, busy); end
    checks++; if (cycle_count !== 0 || instr_count !== 0) begin fails++; $display("FAIL reset counters got %0d/%0d exp 0/0", cycle_count, instr_count); end
    checks++; if ({imem_req, dmem_req, fetch_en, decode_en, exec_en, mem_en, wb_en} !== 7'b0) begin
      fails++; $display("FAIL reset strobes got %b exp 0", {imem_req, dmem_req, fetch_en, decode_en, exec_en, mem_en, wb_en}); end
    rst = 0;
    imem_ack = 0; dmem_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_restart;
    do_start(64'h40);
    checks++; if (stat !== 3'd1 || busy !== 1'b1 || pc !== 64'h40) begin
      fails++; $display("FAIL restart stat/busy/pc got %0d/%b/%h exp 1/1/40", stat, busy, pc); end
    checks++; if (cycle_count !== 0 || instr_count !== 0) begin
      fails++; $display("FAIL restart counters got %0d/%0d exp 0/0", cycle_count, instr_count); end
  endtask

  task automatic test_back_to_back;
    do_start(64'h70);
    exec_instr(4'h3, 1, 0, 0, 64'h7a, 1, 0, 0, "irmovq");
    exec_instr(4'h4, 1, 0, 0, 64'h84, 0, 0, 0, "rmmovq");
    exec_instr(4'h6, 1, 0, 0, 64'h86, 2, 0, 1, "opq");
    exec_instr(4'h8, 1, 0, 0, 64'h200, 0, 1, 0, "call");
    exec_instr(4'h9, 1, 0, 0, 64'h8f, 0, 2, 0, "ret");
    exec_instr(4'hB, 1, 0, 0, 64'h91, 0, 0, 0, "popq");
    exec_instr(4'h7, 1, 0, 0, 64'h300, 0, 0, 0, "jxx");
    exec_instr(4'h0, 1, 0, 0, 64'h301, 0, 0, 0, "halt2");
  endtask

  task automatic test_reset_mid;
    int k = 0;
    do_start(64'h80);
    icode = 4'h5; instr_valid = 1; imem_error = 0; dmem_error = 0;
    while (!dmem_req && k < 20) begin
      imem_ack = imem_req; dmem_ack = 0;
      @(negedge clk);
      k++;
    end
    imem_ack = 0;
    checks++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rst_mid dmem_req before reset got %b exp 1", dmem_req); end
    #1 rst = 1;
    #1;
    checks++; if (dmem_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid req/busy got %b/%b exp 0/0", dmem_req, busy); end
    checks++; if (pc !== RPC || instr_count !== 0) begin fails++; $display("FAIL rst_mid pc/icnt got %h/%0d exp %h/0", pc, instr_count, RPC); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || stat !== 3'd1) begin fails++; $display("FAIL rst_mid idle busy/stat got %b/%0d exp 0/1", busy, stat); end
  endtask

  initial begin
    test_reset;
    do_start(64'h0);
    exec_instr(4'h1, 1, 0, 0, 64'h1, 0, 0, 1, "nop");
    exec_instr(4'h5, 1, 0, 0, 64'hb, 0, 3, 0, "mrmovq");
    exec_instr(4'h0, 1, 0, 0, 64'h21, 0, 0, 0, "halt");
    test_restart;
    exec_instr(4'hF, 0, 0, 0, 64'h99, 0, 0, 0, "invalid");
    do_start(64'h50);
    exec_instr(4'hA, 1, 0, 1, 64'h52, 1, 1, 0, "pushq_derr");
    do_start(64'h60);
    exec_instr(4'h2, 0, 1, 0, 64'h62, 2, 0, 0, "imem_err");
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/y86_seq_ctrl.md
# y86_seq_ctrl

Multi-cycle stage sequencer for the Y86-64 SEQ datapath. Steps each instruction through fetch, decode, execute, memory, writeback and PC update with one-cycle stage strobes, handshakes with instruction and data memory, and owns the architectural PC register (loaded from the combinational next-PC logic) plus the processor status code. Also keeps cycle and retired-instruction counters for the testbench and debug.

## Interface

- RESET_PC, 64'd0, PC value loaded on reset
- CNT_W, 32, width of cycle_count and instr_count

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution at start_pc; honoured only in IDLE or HALTED
- start_pc  in  64  initial PC captured on start
- icode  in  4  instruction code from fetch logic; valid while imem_ack=1 and held by datapath thereafter
- instr_valid  in  1  fetch logic reports legal icode/ifun; sampled with imem_ack
- imem_error  in  1  instruction address error; sampled with imem_ack
- next_pc  in  64  output of the PC update logic (valP/valC/valM selection)
- imem_ack  in  1  instruction memory done
- dmem_ack  in  1  data memory done
- dmem_error  in  1  data address error; sampled with dmem_ack
- pc  out  64  architectural PC
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory access request
- fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  one-cycle stage latch strobes
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  out  1  high in every state except IDLE and HALTED
- cycle_count  out  CNT_W  cycles spent busy since last start
- instr_count  out  CNT_W  instructions retired since last start

## Operation

- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- IDLE/HALTED: on start: pc<=start_pc, stat<=1, both counters<=0, go FETCH. Otherwise hold.
- FETCH: imem_req=1 until imem_ack. In the ack cycle: fetch_en=1; if imem_error then stat<=3, go HALTED; else if !instr_valid then stat<=4, go HALTED; else go DECODE. imem_error takes priority over !instr_valid.
- DECODE: decode_en=1, go EXECUTE.
- EXECUTE: exec_en=1; go MEMORY if icode is 4,5,8,9,A or B (rmmovq, mrmovq, call, ret, pushq, popq), else WRITEBACK.
- MEMORY: dmem_req=1 until dmem_ack. In the ack cycle: if dmem_error then stat<=3, go HALTED, no mem_en, no writeback, PC unchanged; else mem_en=1, go WRITEBACK.
- WRITEBACK: wb_en=1, go PCUPD.
- PCUPD: pc<=next_pc, instr_count+1; if icode==0 then stat<=2, go HALTED; else go FETCH.
- start while busy is ignored. A faulting instruction is not counted in instr_count.
- cycle_count increments on every clock edge where busy=1 and saturates at all-ones. instr_count also saturates.

## Timing

- Reset (async, immediate): state IDLE, pc=RESET_PC, stat=1, counters 0, all requests and strobes 0, busy 0.
- All strobes and requests decode from the registered state. fetch_en additionally requires imem_ack in the same cycle. mem_en additionally requires dmem_ack and !dmem_error.
- Each strobe lasts exactly one cycle per instruction. No strobe is active in IDLE or HALTED.
- Latency with zero-wait memory (ack in the first request cycle): 5 cycles for a non-memory instruction, 6 for a memory instruction. Each memory wait cycle adds 1.
- pc changes only on the PCUPD to next-state edge or on start. next_pc is sampled in PCUPD only.
- rst asserted mid-instruction aborts immediately. Requests drop in the same cycle. Nothing is retired.

## Test plan

- Reset with RESET_PC=0x100 -> pc=0x100, stat=1, busy=0, all counters and strobes 0. Then start, start_pc=0x0, nop (icode 1) with immediate acks and next_pc=0x1 -> strobes fetch/decode/exec/wb in cycles 1,2,3,4 (no mem_en); pc=0x1 after cycle 5; instr_count=1.
- mrmovq (icode 5) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, mem_en pulses once, instruction takes 9 cycles, pc<=next_pc.
- halt (icode 0), next_pc=0x21 -> stat=2, pc=0x21, busy=0, instr_count incremented. A second start at 0x40 restarts with stat=1 and counters cleared.
- icode 0xF with instr_valid=0 -> stat=4 after the fetch ack cycle, no decode_en, pc unchanged, instr_count unchanged.
- pushq with dmem_error on ack -> stat=3, no mem_en, no wb_en, pc unchanged. Separately, imem_error together with instr_valid=0 -> stat=3.
- rst pulsed while dmem_req=1 -> dmem_req low immediately, IDLE, pc=RESET_PC. start asserted mid-instruction -> no effect on pc or counters.
